// File: rtl/up_axi_master.sv
// rtl/up_axi_master.sv - up_* register requests to AXI4-Lite master, one outstanding transaction
// Optional slave watchdog: define UP_AXI_MASTER_TIMEOUT_EN
module up_axi_master #(
  parameter int ADDRESS_WIDTH  = 14,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     up_clk,
  input  logic                     up_rst,
  input  logic                     up_wreq,
  input  logic [ADDRESS_WIDTH-1:0] up_waddr,
  input  logic [31:0]              up_wdata,
  output logic                     up_wack,
  output logic                     up_werr,
  input  logic                     up_rreq,
  input  logic [ADDRESS_WIDTH-1:0] up_raddr,
  output logic [31:0]              up_rdata,
  output logic                     up_rack,
  output logic                     up_rerr,
  output logic                     up_busy,
  output logic                     m_axi_awvalid,
  output logic [ADDRESS_WIDTH+1:0] m_axi_awaddr,
  output logic [2:0]               m_axi_awprot,
  input  logic                     m_axi_awready,
  output logic                     m_axi_wvalid,
  output logic [31:0]              m_axi_wdata,
  output logic [3:0]               m_axi_wstrb,
  input  logic                     m_axi_wready,
  input  logic                     m_axi_bvalid,
  input  logic [1:0]               m_axi_bresp,
  output logic                     m_axi_bready,
  output logic                     m_axi_arvalid,
  output logic [ADDRESS_WIDTH+1:0] m_axi_araddr,
  output logic [2:0]               m_axi_arprot,
  input  logic                     m_axi_arready,
  input  logic                     m_axi_rvalid,
  input  logic [1:0]               m_axi_rresp,
  input  logic [31:0]              m_axi_rdata,
  output logic                     m_axi_rready
);

  typedef enum logic [2:0] {IDLE, WR, WRESP, RD, RDATA} state_t;

  state_t                   state, state_n;
  logic [ADDRESS_WIDTH-1:0] addr_q, pend_addr;
  logic [31:0]              wdata_q;
  logic                     aw_done, w_done, pend_rd, tmo;
  logic                     aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign m_axi_awvalid = (state == WR) && !aw_done;
  assign m_axi_wvalid  = (state == WR) && !w_done;
  assign m_axi_bready  = (state == WRESP);
  assign m_axi_arvalid = (state == RD);
  assign m_axi_rready  = (state == RDATA);
  assign m_axi_awaddr  = {addr_q, 2'b00};
  assign m_axi_araddr  = {addr_q, 2'b00};
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_arprot  = 3'b000;
  assign up_busy       = (state != IDLE) || pend_rd;

  assign aw_hs = m_axi_awvalid && m_axi_awready;
  assign w_hs  = m_axi_wvalid && m_axi_wready;
  assign b_hs  = m_axi_bready && m_axi_bvalid;
  assign ar_hs = m_axi_arvalid && m_axi_arready;
  assign r_hs  = m_axi_rready && m_axi_rvalid;

`ifdef UP_AXI_MASTER_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt;
  logic        any_hs;

  assign any_hs = aw_hs || w_hs || b_hs || ar_hs || r_hs;

  always_ff @(posedge up_clk) begin
    if (up_rst || state == IDLE || any_hs) tmo_cnt <= '0;
    else                                  tmo_cnt <= tmo_cnt + 16'd1;
  end

  // fires after TIMEOUT_CYCLES consecutive non-idle clocks without a handshake
  assign tmo = (state != IDLE) && !any_hs && (tmo_cnt == TMO_LAST);
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (pend_rd)      state_n = RD;
        else if (up_wreq) state_n = WR;
        else if (up_rreq) state_n = RD;
      end
      WR:      if ((aw_done || aw_hs) && (w_done || w_hs)) state_n = WRESP;
      WRESP:   if (b_hs) state_n = IDLE;
      RD:      if (ar_hs) state_n = RDATA;
      RDATA:   if (r_hs) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (tmo) state_n = IDLE;
  end

  always_ff @(posedge up_clk) begin
    if (up_rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      pend_addr <= '0;
      wdata_q   <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      pend_rd   <= 1'b0;
      up_wack   <= 1'b0;
      up_werr   <= 1'b0;
      up_rack   <= 1'b0;
      up_rerr   <= 1'b0;
      up_rdata  <= '0;
    end else begin
      state   <= state_n;
      up_wack <= 1'b0;
      up_werr <= 1'b0;
      up_rack <= 1'b0;
      up_rerr <= 1'b0;
      case (state)
        IDLE: begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          if (pend_rd) begin
            addr_q  <= pend_addr;
            pend_rd <= 1'b0;
          end else if (up_wreq) begin
            addr_q  <= up_waddr;
            wdata_q <= up_wdata;
            // simultaneous read is parked and issued once the write acks
            if (up_rreq) begin
              pend_rd   <= 1'b1;
              pend_addr <= up_raddr;
            end
          end else if (up_rreq) begin
            addr_q <= up_raddr;
          end
        end
        WR: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
        end
        WRESP: if (b_hs) begin
          up_wack <= 1'b1;
          up_werr <= (m_axi_bresp != 2'b00);
        end
        RDATA: if (r_hs) begin
          up_rack  <= 1'b1;
          up_rerr  <= (m_axi_rresp != 2'b00);
          up_rdata <= m_axi_rdata;
        end
        default: ;
      endcase
      if (tmo) begin
        pend_rd <= 1'b0;
        if (state == WR || state == WRESP) begin
          up_wack <= 1'b1;
          up_werr <= 1'b1;
        end else begin
          up_rack  <= 1'b1;
          up_rerr  <= 1'b1;
          up_rdata <= 32'hDEADDEAD;
        end
      end
    end
  end

endmodule

// File: tb/tb_up_axi_master.sv
// tb/tb_up_axi_master.sv - scoreboard bench for up_axi_master against a behavioural AXI-Lite slave
module tb_up_axi_master;

  logic        up_clk = 1'b0;
  logic        up_rst = 1'b1;
  logic        up_wreq = 1'b0, up_rreq = 1'b0;
  logic [13:0] up_waddr = '0, up_raddr = '0;
  logic [31:0] up_wdata = '0;
  logic        up_wack, up_werr, up_rack, up_rerr, up_busy;
  logic [31:0] up_rdata;
  logic        m_axi_awvalid, m_axi_awready = 1'b0;
  logic [15:0] m_axi_awaddr, m_axi_araddr;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic        m_axi_wvalid, m_axi_wready = 1'b0;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_bvalid = 1'b0, m_axi_bready;
  logic [1:0]  m_axi_bresp = 2'b00;
  logic        m_axi_arvalid, m_axi_arready = 1'b0;
  logic        m_axi_rvalid = 1'b0, m_axi_rready;
  logic [1:0]  m_axi_rresp = 2'b00;
  logic [31:0] m_axi_rdata = '0;

  up_axi_master #(.ADDRESS_WIDTH(14), .TIMEOUT_CYCLES(8)) dut (
    .up_clk(up_clk), .up_rst(up_rst),
    .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata),
    .up_wack(up_wack), .up_werr(up_werr),
    .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata),
    .up_rack(up_rack), .up_rerr(up_rerr), .up_busy(up_busy),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awready(m_axi_awready),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wready(m_axi_wready),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bresp(m_axi_bresp), .m_axi_bready(m_axi_bready),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arready(m_axi_arready),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rresp(m_axi_rresp), .m_axi_rdata(m_axi_rdata),
    .m_axi_rready(m_axi_rready)
  );

  initial forever #5 up_clk = ~up_clk;

  int cyc = 0;
  initial forever begin
    @(posedge up_clk);
    cyc++;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit          is_rd;
    bit          err;
    logic [31:0] data;
    logic [15:0] addr;
    bit          chk_addr;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  // slave configuration and observed traffic
  int          aw_delay = 0;
  bit          ar_stuck = 1'b0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [15:0] seen_awaddr = '0, seen_araddr = '0;
  logic [3:0]  seen_wstrb = '0;
  logic [31:0] mem [16];

  initial begin
    int          aw_wait;
    bit          aw_got, w_got, b_pend, r_pend;
    logic [31:0] w_data, rd_val;
    aw_wait = 0; aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; w_data = '0; rd_val = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    forever begin
      @(negedge up_clk);
      if (up_rst) begin
        aw_wait = 0; aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_arready = 0; m_axi_rvalid = 0;
      end else begin
        m_axi_bvalid = b_pend;
        m_axi_bresp  = bresp_cfg;
        if (b_pend && m_axi_bready) b_pend = 0;
        m_axi_awready = m_axi_awvalid && (aw_wait >= aw_delay);
        if (m_axi_awvalid && !m_axi_awready) aw_wait++;
        if (m_axi_awvalid && m_axi_awready) begin
          aw_got = 1; aw_wait = 0; seen_awaddr = m_axi_awaddr;
        end
        m_axi_wready = m_axi_wvalid;
        if (m_axi_wvalid && m_axi_wready) begin
          w_got = 1; w_data = m_axi_wdata; seen_wstrb = m_axi_wstrb;
        end
        if (aw_got && w_got) begin
          mem[seen_awaddr[5:2]] = w_data;
          b_pend = 1; aw_got = 0; w_got = 0;
        end
        m_axi_rvalid = r_pend;
        m_axi_rdata  = r_pend ? rd_val : 32'h0;
        m_axi_rresp  = rresp_cfg;
        if (r_pend && m_axi_rready) r_pend = 0;
        m_axi_arready = m_axi_arvalid && !ar_stuck;
        if (m_axi_arvalid && m_axi_arready) begin
          r_pend = 1; seen_araddr = m_axi_araddr;
          rd_val = (m_axi_araddr[15:2] == 14'd3) ? 32'h53594944 : mem[m_axi_araddr[5:2]];
        end
      end
    end
  end

  // monitor: every ack pops one expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge up_clk);
      if (up_wack || up_rack) begin
        chk("ack_both", {31'b0, up_wack && up_rack}, 32'd0);
        if (sb.size() == 0) begin
          chk("unexpected_ack", {30'b0, up_wack, up_rack}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("ack_kind", {31'b0, up_rack}, {31'b0, e.is_rd});
          if (e.is_rd) begin
            chk("rerr", {31'b0, up_rerr}, {31'b0, e.err});
            chk("rdata", up_rdata, e.data);
            if (e.chk_addr) chk("araddr", {16'b0, seen_araddr}, {16'b0, e.addr});
          end else begin
            chk("werr", {31'b0, up_werr}, {31'b0, e.err});
            if (e.chk_addr) begin
              chk("awaddr", {16'b0, seen_awaddr}, {16'b0, e.addr});
              chk("wstrb", {28'b0, seen_wstrb}, 32'hF);
            end
          end
          if (e.cyc >= 0) chk("ack_latency", cyc, e.cyc);
        end
      end
    end
  end

  task automatic issue(input bit w, input bit r, input logic [13:0] wa, input logic [31:0] wd,
                       input logic [13:0] ra, output int c0);
    @(negedge up_clk);
    up_wreq = w; up_waddr = wa; up_wdata = wd;
    up_rreq = r; up_raddr = ra;
    c0 = cyc;
    @(negedge up_clk);
    up_wreq = 0; up_rreq = 0;
  endtask

  task automatic push(input bit is_rd, input bit err, input logic [31:0] d,
                      input logic [15:0] a, input bit ca, input int c);
    exp_t e;
    e.is_rd = is_rd; e.err = err; e.data = d; e.addr = a; e.chk_addr = ca; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge up_clk);
      if (sb.size() == 0 && !up_busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("wait_done_timeout", sb.size(), 32'd0);
  endtask

  initial begin
    int c0;
    repeat (2) @(negedge up_clk);
    chk("reset_ctrl", {22'b0, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                       m_axi_rready, up_wack, up_rack, up_werr, up_rerr, up_busy}, 32'd0);
    chk("reset_rdata", up_rdata, 32'd0);
    up_rst = 0;

    // zero-wait write, valids checked in cycle 1
    issue(1, 0, 14'h02, 32'h12345678, 14'h0, c0);
    push(0, 0, 32'h0, 16'h0008, 1, c0 + 3);
    chk("wr_valids_c1", {30'b0, m_axi_awvalid, m_axi_wvalid}, 32'h3);
    chk("wr_awaddr_c1", {16'b0, m_axi_awaddr}, 32'h0008);
    chk("wr_prot_strb", {25'b0, m_axi_awprot, m_axi_wstrb}, 32'h0F);
    wait_done();

    // sys_id read
    issue(0, 1, 14'h0, 32'h0, 14'h03, c0);
    push(1, 0, 32'h53594944, 16'h000C, 1, c0 + 3);
    wait_done();

    // awready held off 5 cycles
    aw_delay = 5;
    issue(1, 0, 14'h05, 32'hA5A50001, 14'h0, c0);
    push(0, 0, 32'h0, 16'h0014, 1, c0 + 8);
    @(negedge up_clk);
    chk("slow_aw_c2", {30'b0, m_axi_awvalid, m_axi_wvalid}, 32'h2);
    repeat (4) @(negedge up_clk);
    chk("slow_aw_c6", {31'b0, m_axi_awvalid}, 32'h1);
    @(negedge up_clk);
    chk("slow_aw_c7", {31'b0, m_axi_awvalid}, 32'h0);
    wait_done();
    aw_delay = 0;

    // simultaneous write and read to the same word
    issue(1, 1, 14'h02, 32'hCAFEF00D, 14'h02, c0);
    push(0, 0, 32'h0, 16'h0008, 1, c0 + 3);
    push(1, 0, 32'hCAFEF00D, 16'h0008, 1, c0 + 6);
    repeat (2) @(negedge up_clk);
    chk("busy_between", {31'b0, up_busy}, 32'h1);
    wait_done();

    // error responses
    bresp_cfg = 2'b10;
    issue(1, 0, 14'h04, 32'h0BAD0BAD, 14'h0, c0);
    push(0, 1, 32'h0, 16'h0010, 1, c0 + 3);
    wait_done();
    bresp_cfg = 2'b00; rresp_cfg = 2'b11;
    issue(0, 1, 14'h0, 32'h0, 14'h04, c0);
    push(1, 1, 32'h0BAD0BAD, 16'h0010, 1, c0 + 3);
    wait_done();
    rresp_cfg = 2'b00;

    // a write while busy is dropped and never reaches the slave
    issue(0, 1, 14'h0, 32'h0, 14'h03, c0);
    push(1, 0, 32'h53594944, 16'h000C, 1, c0 + 3);
    issue(1, 0, 14'h06, 32'hFFFFFFFF, 14'h0, c0);
    wait_done();
    issue(0, 1, 14'h0, 32'h0, 14'h06, c0);
    push(1, 0, 32'h0, 16'h0018, 1, c0 + 3);
    wait_done();

    // reset in the middle of a stalled write
    aw_delay = 100;
    issue(1, 0, 14'h07, 32'h77777777, 14'h0, c0);
    up_rst = 1;
    @(negedge up_clk);
    chk("midrst_outputs", {26'b0, m_axi_awvalid, m_axi_wvalid, m_axi_bready, up_wack,
                           up_rack, up_busy}, 32'd0);
    @(negedge up_clk);
    up_rst = 0; aw_delay = 0;
    repeat (5) @(negedge up_clk);
    issue(0, 1, 14'h0, 32'h0, 14'h07, c0);
    push(1, 0, 32'h0, 16'h001C, 1, c0 + 3);
    wait_done();

`ifdef UP_AXI_MASTER_TIMEOUT_EN
    ar_stuck = 1;
    issue(0, 1, 14'h0, 32'h0, 14'h03, c0);
    push(1, 1, 32'hDEADDEAD, 16'h0, 0, c0 + 9);
    wait_done();
    chk("tmo_arvalid_low", {31'b0, m_axi_arvalid}, 32'h0);
    ar_stuck = 0;
`endif

    repeat (3) @(negedge up_clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
